// File: rtl/riscv_i32_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_i32_pkg                                                    |
// | Shared dmem access types and responder state encoding.           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_i32_pkg;

  localparam int WAIT_COUNTER_WIDTH = 4;

  typedef struct packed {
    logic [31:0] address;
    logic [3:0]  byte_enable;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] write_data;
  } t_dmem_access_req;

  // "wait" is a keyword, hence wait_req
  typedef struct packed {
    logic        wait_req;
    logic [31:0] read_data;
  } t_dmem_access_resp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    DATA  = 2'd2
  } t_dmem_responder_state;

endpackage
`default_nettype wire

// File: rtl/riscv_i32_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_i32_dmem_responder                                         |
// | dmem target: drives a single-port SRAM with optional wait states.|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module riscv_i32_dmem_responder
  import riscv_i32_pkg::*;
#(
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned MEM_ADDR_WIDTH = 12,
  parameter logic [31:0] MEM_BASE       = 32'h0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               dmem_access_req__address,
  input  logic [3:0]                dmem_access_req__byte_enable,
  input  logic                      dmem_access_req__write_enable,
  input  logic                      dmem_access_req__read_enable,
  input  logic [31:0]               dmem_access_req__write_data,
  output logic                      dmem_access_resp__wait,
  output logic [31:0]               dmem_access_resp__read_data,
  output logic                      sram_select,
  output logic                      sram_read_not_write,
  output logic [MEM_ADDR_WIDTH-1:0] sram_address,
  output logic [3:0]                sram_byte_enable,
  output logic [31:0]               sram_write_data,
  input  logic [31:0]               sram_read_data
);

  localparam logic [31:0] C_WIN_MASK = ~((32'd4 << MEM_ADDR_WIDTH) - 32'd1);
  localparam bit          C_NO_WAIT  = (WAIT_STATES == 0);
  localparam logic [WAIT_COUNTER_WIDTH-1:0] C_CNT_INIT =
    (WAIT_STATES == 0) ? '0 : WAIT_COUNTER_WIDTH'(WAIT_STATES - 1);

  t_dmem_responder_state          state_q, state_d;
  logic [WAIT_COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  t_dmem_access_req               req_q, req_d;
  logic                           in_range_q, in_range_d;
  logic                           data_ok_q, data_ok_d;
  logic [31:0]                    rdata_q, rdata_d;

  t_dmem_access_req  req_w;
  t_dmem_access_resp resp_w;
  t_dmem_access_req  iss_req_w;
  logic              iss_w, iss_in_w;
  logic              valid_w, accept_w, in_range_w;
  logic [31:0]       data_word_w;
  logic              unused_w;

  assign req_w.address      = dmem_access_req__address;
  assign req_w.byte_enable  = dmem_access_req__byte_enable;
  assign req_w.write_enable = dmem_access_req__write_enable;
  assign req_w.read_enable  = dmem_access_req__read_enable;
  assign req_w.write_data   = dmem_access_req__write_data;

  assign valid_w     = req_w.read_enable | req_w.write_enable;
  assign accept_w    = valid_w && (state_q != STALL);
  assign in_range_w  = (req_w.address & C_WIN_MASK) == MEM_BASE;
  assign data_word_w = data_ok_q ? sram_read_data : 32'h0;

  assign resp_w.wait_req  = (state_q == STALL);
  assign resp_w.read_data = (state_q == DATA) ? data_word_w : rdata_q;
  assign dmem_access_resp__wait      = resp_w.wait_req;
  assign dmem_access_resp__read_data = resp_w.read_data;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    in_range_d = in_range_q;
    data_ok_d  = data_ok_q;
    rdata_d    = rdata_q;
    iss_w      = 1'b0;
    iss_req_w  = req_q;
    iss_in_w   = in_range_q;
    sram_select         = 1'b0;
    sram_read_not_write = 1'b0;
    sram_address        = '0;
    sram_byte_enable    = 4'h0;
    sram_write_data     = 32'h0;

    case (state_q)
      DATA: begin
        rdata_d = data_word_w;
        state_d = IDLE;
      end
      STALL: begin
        if (cnt_q == '0) begin
          iss_w     = 1'b1;
          data_ok_d = in_range_q;
          state_d   = req_q.write_enable ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase

    // A DATA cycle may accept the next request; that overrides the return to IDLE
    if (accept_w) begin
      if (C_NO_WAIT) begin
        iss_w     = 1'b1;
        iss_req_w = req_w;
        iss_in_w  = in_range_w;
        data_ok_d = in_range_w;
        state_d   = req_w.write_enable ? IDLE : DATA;
      end else begin
        req_d      = req_w;
        in_range_d = in_range_w;
        cnt_d      = C_CNT_INIT;
        state_d    = STALL;
      end
    end

    if (iss_w && iss_in_w) begin
      sram_select         = 1'b1;
      sram_read_not_write = ~iss_req_w.write_enable;
      sram_address        = iss_req_w.address[MEM_ADDR_WIDTH+1:2];
      sram_byte_enable    = iss_req_w.byte_enable;
      sram_write_data     = iss_req_w.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      in_range_q <= 1'b0;
      data_ok_q  <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      in_range_q <= in_range_d;
      data_ok_q  <= data_ok_d;
      rdata_q    <= rdata_d;
    end
  end

  assign unused_w = ^{req_q.read_enable, req_q.address[1:0],
                      req_q.address[31:MEM_ADDR_WIDTH+2], req_w.address[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_riscv_i32_dmem_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_riscv_i32_dmem_responder                                      |
// | Three responders (W=0,3,4) against a word-level reference model. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_riscv_i32_dmem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] addr[NI], wd[NI], rd[NI], swd[NI], srd[NI];
  logic [3:0]  be[NI], sbe[NI];
  logic        we[NI], re[NI], wt[NI], sel[NI], rnw[NI];
  logic [11:0] sa[NI];

  logic [31:0] mdl[NI][4096];
  int n_pass = 0;
  int n_total = 0;

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [31:0] mem [0:4095];
    logic [31:0] rq = 32'h0;

    riscv_i32_dmem_responder #(
      .WAIT_STATES    ((gi == 0) ? 0 : ((gi == 1) ? 3 : 4)),
      .MEM_ADDR_WIDTH (12),
      .MEM_BASE       (32'h0)
    ) u_dut (
      .clk                           (clk),
      .reset                         (rst),
      .dmem_access_req__address      (addr[gi]),
      .dmem_access_req__byte_enable  (be[gi]),
      .dmem_access_req__write_enable (we[gi]),
      .dmem_access_req__read_enable  (re[gi]),
      .dmem_access_req__write_data   (wd[gi]),
      .dmem_access_resp__wait        (wt[gi]),
      .dmem_access_resp__read_data   (rd[gi]),
      .sram_select                   (sel[gi]),
      .sram_read_not_write           (rnw[gi]),
      .sram_address                  (sa[gi]),
      .sram_byte_enable              (sbe[gi]),
      .sram_write_data               (swd[gi]),
      .sram_read_data                (srd[gi])
    );

    initial for (int k = 0; k < 4096; k++) mem[k] = 32'h0;

    always @(posedge clk) begin
      if (sel[gi]) begin
        if (rnw[gi]) rq <= mem[sa[gi]];
        else for (int b = 0; b < 4; b++)
          if (sbe[gi][b]) mem[sa[gi]][8*b +: 8] <= swd[gi][8*b +: 8];
      end
    end
    assign srd[gi] = rq;
  end

  function automatic int ws_of(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 3 : 4);
  endfunction

  // Window is 16 KiB at base 0
  function automatic bit in_rng(input logic [31:0] a);
    return a[31:14] == 18'h0;
  endfunction

  task automatic idle_inputs(input int i);
    addr[i] = 32'h0; be[i] = 4'h0; we[i] = 1'b0; re[i] = 1'b0; wd[i] = 32'h0;
  endtask

  // One complete transaction on instance i with cycle-by-cycle checks
  task automatic access(input int i, input bit w, input bit r, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
    int ws;
    bit inr, is_rd, esel, ewt;
    logic [31:0] exp;
    ws    = ws_of(i);
    inr   = in_rng(a);
    is_rd = r && !w;
    exp   = inr ? mdl[i][a[13:2]] : 32'h0;
    @(negedge clk);
    addr[i] = a; be[i] = b; we[i] = w; re[i] = r; wd[i] = d;
    #1;
    for (int k = 0; k <= ws + 1; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      ewt = (k >= 1) && (k <= ws);
      n_total++;
      if (wt[i] !== ewt) $display("FAIL wait inst%0d a=%h k=%0d got=%b exp=%b", i, a, k, wt[i], ewt);
      else n_pass++;
      if (k <= ws) begin
        esel = (k == ws) && inr;
        n_total++;
        if (sel[i] !== esel) $display("FAIL sram_select inst%0d a=%h k=%0d got=%b exp=%b", i, a, k, sel[i], esel);
        else n_pass++;
        if (esel) begin
          n_total++;
          if (rnw[i] !== !w || sa[i] !== a[13:2])
            $display("FAIL sram_cmd inst%0d got rnw=%b addr=%h exp rnw=%b addr=%h", i, rnw[i], sa[i], !w, a[13:2]);
          else n_pass++;
          if (w) begin
            n_total++;
            if (sbe[i] !== b || swd[i] !== d)
              $display("FAIL sram_wr inst%0d got be=%h d=%h exp be=%h d=%h", i, sbe[i], swd[i], b, d);
            else n_pass++;
          end
        end
      end
      if (k == ws + 1 && is_rd) begin
        n_total++;
        if (rd[i] !== exp) $display("FAIL read_data inst%0d a=%h got=%h exp=%h", i, a, rd[i], exp);
        else n_pass++;
      end
    end
    if (w && inr)
      for (int j = 0; j < 4; j++)
        if (b[j]) mdl[i][a[13:2]][8*j +: 8] = d[8*j +: 8];
    idle_inputs(i);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NI; i++) idle_inputs(i);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      n_total++;
      if (wt[i] !== 1'b0 || sel[i] !== 1'b0 || rd[i] !== 32'h0)
        $display("FAIL reset_state inst%0d got wait=%b sel=%b rd=%h exp 0/0/0", i, wt[i], sel[i], rd[i]);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read_w0();
    access(0, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
    access(0, 0, 1, 32'h10, 4'h0, 32'h0);
    n_total++;
    if (rd[0] !== 32'hDEADBEEF) $display("FAIL w0_readback got=%h exp=%h", rd[0], 32'hDEADBEEF);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    access(0, 1, 0, 32'h20, 4'hF, 32'h11223344);
    access(0, 1, 0, 32'h20, 4'b0010, 32'h0000AB00);
    access(0, 0, 1, 32'h22, 4'h0, 32'h0);
    n_total++;
    if (rd[0] !== 32'h1122AB44) $display("FAIL partial_write got=%h exp=%h", rd[0], 32'h1122AB44);
    else n_pass++;
  endtask

  task automatic test_wait_states();
    access(1, 1, 0, 32'h10, 4'hF, 32'hDEADBEEF);
    access(1, 0, 1, 32'h10, 4'h0, 32'h0);
    n_total++;
    if (rd[1] !== 32'hDEADBEEF) $display("FAIL w3_readback got=%h exp=%h", rd[1], 32'hDEADBEEF);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp[4];
    for (int j = 0; j < 4; j++) access(0, 1, 0, 32'(4*j), 4'hF, $urandom);
    for (int j = 0; j < 4; j++) exp[j] = mdl[0][j];
    for (int j = 0; j <= 4; j++) begin
      @(negedge clk); #1;
      if (j > 0) begin
        n_total++;
        if (rd[0] !== exp[j-1] || wt[0] !== 1'b0)
          $display("FAIL b2b_data idx%0d got=%h wait=%b exp=%h wait=0", j-1, rd[0], wt[0], exp[j-1]);
        else n_pass++;
      end
      if (j < 4) begin
        addr[0] = 32'(4*j); re[0] = 1'b1; we[0] = 1'b0;
        #1;
        n_total++;
        if (sel[0] !== 1'b1 || rnw[0] !== 1'b1 || sa[0] !== 12'(j))
          $display("FAIL b2b_issue idx%0d got sel=%b rnw=%b addr=%h exp 1/1/%h", j, sel[0], rnw[0], sa[0], 12'(j));
        else n_pass++;
      end else idle_inputs(0);
    end
  endtask

  task automatic test_out_of_range();
    for (int i = 0; i < 2; i++) begin
      access(i, 1, 0, 32'h4000, 4'hF, 32'h55);
      access(i, 0, 1, 32'h4000, 4'h0, 32'h0);
      n_total++;
      if (rd[i] !== 32'h0) $display("FAIL oor_read inst%0d got=%h exp=%h", i, rd[i], 32'h0);
      else n_pass++;
    end
  endtask

  task automatic test_reset_abort();
    access(2, 1, 0, 32'h30, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    addr[2] = 32'h30; be[2] = 4'hF; we[2] = 1'b1; re[2] = 1'b0; wd[2] = 32'h12345678;
    #1;
    n_total++;
    if (wt[2] !== 1'b0 || sel[2] !== 1'b0) $display("FAIL abort_accept got wait=%b sel=%b exp 0/0", wt[2], sel[2]);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (wt[2] !== 1'b1) $display("FAIL abort_stall got wait=%b exp 1", wt[2]);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_total++;
    if (sel[2] !== 1'b0) $display("FAIL abort_nosel got=%b exp 0", sel[2]);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (wt[2] !== 1'b0 || sel[2] !== 1'b0) $display("FAIL abort_release got wait=%b sel=%b exp 0/0", wt[2], sel[2]);
    else n_pass++;
    rst = 1'b0;
    idle_inputs(2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      n_total++;
      if (sel[2] !== 1'b0) $display("FAIL abort_late_sel cyc%0d got=%b exp 0", k, sel[2]);
      else n_pass++;
    end
    access(2, 0, 1, 32'h30, 4'h0, 32'h0);
    n_total++;
    if (rd[2] !== 32'hCAFEF00D) $display("FAIL abort_old_value got=%h exp=%h", rd[2], 32'hCAFEF00D);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      int i, kind;
      logic [31:0] a;
      i    = int'($urandom_range(0, NI-1));
      kind = int'($urandom_range(0, 3));
      a    = (($urandom_range(0, 7) == 0) ? 32'h4000 : 32'h0) |
             32'($urandom_range(0, 15) << 2) | 32'($urandom_range(0, 3));
      case (kind)
        0, 3: access(i, 0, 1, a, 4'($urandom), 32'h0);
        1:    access(i, 1, 0, a, 4'($urandom), $urandom);
        default: access(i, 1, 1, a, 4'($urandom), $urandom);
      endcase
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 4096; k++) mdl[i][k] = 32'h0;
    test_reset();
    test_write_read_w0();
    test_partial_write();
    test_wait_states();
    test_back_to_back();
    test_out_of_range();
    test_reset_abort();
    test_random();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
